// File: rtl/axis_pkg.sv
// Shared definitions for the byte-keyed AXI-stream width converters.
package axis_pkg;

  localparam int unsigned RATIO_DEF = 4;
  localparam int unsigned IDX_W     = $clog2(RATIO_DEF);
  localparam int unsigned KEEP_MAX  = 64;

  // Highest slice index holding any valid byte; 0 when the mask is empty.
  function automatic int unsigned last_slice(input logic [KEEP_MAX-1:0] keep,
                                             input int unsigned nbytes,
                                             input int unsigned ratio);
    int unsigned per;
    per        = nbytes / ratio;
    last_slice = 0;
    for (int unsigned b = 0; b < KEEP_MAX; b++) begin
      if (b < nbytes && keep[b]) last_slice = b / per;
    end
  endfunction

endpackage

// File: rtl/axis_downsizer.sv
// Splits each wide AXI-stream word into RATIO narrow beats, lowest lane first,
// dropping empty trailing slices of a packet's final word.
module axis_downsizer
  import axis_pkg::*;
#(
  parameter  int unsigned IN_BYTES  = 8,
  parameter  int unsigned RATIO     = RATIO_DEF,
  localparam int unsigned OUT_BYTES = IN_BYTES / RATIO
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_valid,
  output logic                    i_ready,
  input  logic [8*IN_BYTES-1:0]   i_data,
  input  logic [IN_BYTES-1:0]     i_keep,
  input  logic                    i_last,
  output logic                    o_valid,
  input  logic                    o_ready,
  output logic [8*OUT_BYTES-1:0]  o_data,
  output logic [OUT_BYTES-1:0]    o_keep,
  output logic                    o_last
);

  localparam int unsigned SEL_W = $clog2(RATIO);
  localparam int unsigned OW    = 8 * OUT_BYTES;

  logic [8*IN_BYTES-1:0] word_q, word_d;
  logic [IN_BYTES-1:0]   keep_q, keep_d;
  logic                  last_q, last_d;
  logic                  vld_q, vld_d;
  logic [SEL_W-1:0]      idx_q, idx_d;
  logic [SEL_W-1:0]      fin_q, fin_d;
  logic                  at_fin;

  logic [OW-1:0]         data_sl [RATIO];
  logic [OUT_BYTES-1:0]  keep_sl [RATIO];

  for (genvar s = 0; s < RATIO; s++) begin : g_slice
    assign data_sl[s] = word_q[s*OW +: OW];
    assign keep_sl[s] = keep_q[s*OUT_BYTES +: OUT_BYTES];
  end

  assign at_fin  = (idx_q == fin_q);
  // Refill while the final beat drains so back-to-back words leave no bubble.
  assign i_ready = !vld_q || (at_fin && o_ready);
  assign o_valid = vld_q;
  assign o_data  = data_sl[idx_q];
  assign o_keep  = vld_q ? keep_sl[idx_q] : '0;
  assign o_last  = vld_q && last_q && at_fin;

  always_comb begin
    word_d = word_q;
    keep_d = keep_q;
    last_d = last_q;
    vld_d  = vld_q;
    idx_d  = idx_q;
    fin_d  = fin_q;
    if (vld_q && o_ready) begin
      if (at_fin) vld_d = 1'b0;
      else        idx_d = idx_q + SEL_W'(1);
    end
    if (i_valid && i_ready) begin
      word_d = i_data;
      keep_d = i_keep;
      last_d = i_last;
      vld_d  = 1'b1;
      idx_d  = '0;
      fin_d  = i_last ? SEL_W'(last_slice(KEEP_MAX'(i_keep), IN_BYTES, RATIO))
                      : SEL_W'(RATIO - 1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      word_q <= '0;
      keep_q <= '0;
      last_q <= 1'b0;
      vld_q  <= 1'b0;
      idx_q  <= '0;
      fin_q  <= '0;
    end else begin
      word_q <= word_d;
      keep_q <= keep_d;
      last_q <= last_d;
      vld_q  <= vld_d;
      idx_q  <= idx_d;
      fin_q  <= fin_d;
    end
  end

endmodule

// File: tb/tb_axis_downsizer.sv
// Directed bench for axis_downsizer with IN_BYTES=8, RATIO=4.
module tb_axis_downsizer;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid;
  logic        i_ready;
  logic [63:0] i_data;
  logic [7:0]  i_keep;
  logic        i_last;
  logic        o_valid;
  logic        o_ready;
  logic [15:0] o_data;
  logic [1:0]  o_keep;
  logic        o_last;

  int checks = 0;
  int errors = 0;

  axis_downsizer #(.IN_BYTES(8), .RATIO(4)) dut (
    .clk(clk), .rst(rst),
    .i_valid(i_valid), .i_ready(i_ready), .i_data(i_data), .i_keep(i_keep), .i_last(i_last),
    .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data), .o_keep(o_keep), .o_last(o_last)
  );

  always #5 clk = ~clk;

  // Non-last words must carry a full keep mask.
  always @(posedge clk) begin
    if (!rst && i_valid && !i_last)
      assert (i_keep == 8'hFF) else begin
        errors++;
        $error("FAIL contract observed keep=%h expected ff", i_keep);
      end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_beat(input string tag, input logic [15:0] d, input logic [1:0] k,
                          input logic l);
    chk({tag, "_valid"}, 64'(o_valid), 64'(1'b1));
    chk({tag, "_data"},  64'(o_data),  64'(d));
    chk({tag, "_keep"},  64'(o_keep),  64'(k));
    chk({tag, "_last"},  64'(o_last),  64'(l));
  endtask

  // Byte j of word n is {n[3:0], j[3:0]}.
  function automatic logic [63:0] mk_word(input int n);
    logic [63:0] w;
    for (int j = 0; j < 8; j++) w[8*j +: 8] = 8'((n * 16 + j) & 255);
    return w;
  endfunction

  function automatic logic [15:0] beat(input int n, input int k);
    logic [7:0] lo, hi;
    lo = 8'((n * 16 + 2 * k) & 255);
    hi = 8'((n * 16 + 2 * k + 1) & 255);
    return {hi, lo};
  endfunction

  initial begin
    int          lows, wi, bi, first, last_c, vcnt;
    logic        in_hs, out_hs, prev_stall;
    logic [18:0] prev_out;

    rst = 1'b1; i_valid = 1'b0; i_data = '0; i_keep = '0; i_last = 1'b0; o_ready = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    chk("rst_o_valid", 64'(o_valid), 64'(1'b0));
    chk("rst_o_last",  64'(o_last),  64'(1'b0));
    chk("rst_o_keep",  64'(o_keep),  64'(2'b00));
    chk("rst_i_ready", 64'(i_ready), 64'(1'b1));

    // Full last word, no backpressure.
    i_valid = 1'b1; i_data = 64'h8877665544332211; i_keep = 8'hFF; i_last = 1'b1;
    #1;
    chk("full_accept", 64'(i_ready), 64'(1'b1));
    tick();
    i_valid = 1'b0;
    lows = 0;
    begin
      logic [15:0] exp_d [4];
      exp_d[0] = 16'h2211; exp_d[1] = 16'h4433; exp_d[2] = 16'h6655; exp_d[3] = 16'h8877;
      for (int k = 0; k < 4; k++) begin
        #1;
        chk_beat("full", exp_d[k], 2'b11, k == 3);
        chk("full_i_ready", 64'(i_ready), 64'(k == 3));
        if (!i_ready) lows++;
        tick();
      end
    end
    chk("full_ready_lows", 64'(lows), 64'd3);
    chk("full_idle", 64'(o_valid), 64'(1'b0));

    // Trimmed last word, followed by a zero-keep last word.
    i_valid = 1'b1; i_data = 64'h8877665544332211; i_keep = 8'h07; i_last = 1'b1;
    tick();
    i_data = 64'h000000000000BBAA; i_keep = 8'h00; i_last = 1'b1;
    #1;
    chk_beat("trim0", 16'h2211, 2'b11, 1'b0);
    chk("trim0_i_ready", 64'(i_ready), 64'(1'b0));
    tick();
    #1;
    chk_beat("trim1", 16'h4433, 2'b01, 1'b1);
    chk("trim1_i_ready", 64'(i_ready), 64'(1'b1));
    tick();
    i_valid = 1'b0;
    #1;
    chk_beat("zkeep", 16'hBBAA, 2'b00, 1'b1);
    tick();
    chk("zkeep_idle", 64'(o_valid), 64'(1'b0));

    // Backpressure: o_ready alternates 1,0.
    wi = 0; bi = 0; prev_stall = 1'b0; prev_out = '0;
    for (int c = 0; c < 200 && bi < 32; c++) begin
      i_valid = (wi < 8); i_data = mk_word(wi); i_keep = 8'hFF; i_last = (wi == 7);
      o_ready = (c % 2 == 0);
      #1;
      if (prev_stall) chk("bp_stable", 64'({o_last, o_keep, o_data}), 64'(prev_out));
      if (o_valid) chk_beat("bp", beat(bi / 4, bi % 4), 2'b11, bi == 31);
      in_hs      = i_valid && i_ready;
      out_hs     = o_valid && o_ready;
      prev_stall = o_valid && !o_ready;
      prev_out   = {o_last, o_keep, o_data};
      tick();
      if (in_hs)  wi++;
      if (out_hs) bi++;
    end
    i_valid = 1'b0; o_ready = 1'b1;
    chk("bp_beats", 64'(bi), 64'd32);
    chk("bp_words", 64'(wi), 64'd8);
    tick();

    // Continuous streaming.
    wi = 0; bi = 0; first = -1; last_c = 0; vcnt = 0;
    for (int c = 0; c < 80 && bi < 32; c++) begin
      i_valid = (wi < 8); i_data = mk_word(8 + wi); i_keep = 8'hFF; i_last = (wi == 7);
      o_ready = 1'b1;
      #1;
      if (o_valid) begin
        chk_beat("st", beat(8 + bi / 4, bi % 4), 2'b11, bi == 31);
        if (first < 0) first = c;
        last_c = c;
        vcnt++;
      end
      in_hs  = i_valid && i_ready;
      out_hs = o_valid && o_ready;
      tick();
      if (in_hs)  wi++;
      if (out_hs) bi++;
    end
    i_valid = 1'b0;
    chk("st_valid_cycles", 64'(vcnt), 64'd32);
    chk("st_span", 64'(last_c - first + 1), 64'd32);
    tick();

    // Reset after the second beat of a word.
    i_valid = 1'b1; i_data = mk_word(3); i_keep = 8'hFF; i_last = 1'b1;
    tick();
    i_valid = 1'b0;
    #1;
    chk_beat("mid0", beat(3, 0), 2'b11, 1'b0);
    tick();
    #1;
    chk_beat("mid1", beat(3, 1), 2'b11, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(o_valid), 64'(1'b0));
    chk("mid_rst_last",  64'(o_last),  64'(1'b0));
    chk("mid_rst_ready", 64'(i_ready), 64'(1'b1));
    i_valid = 1'b1; i_data = mk_word(5); i_keep = 8'hFF; i_last = 1'b1;
    tick();
    i_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk_beat("after_rst", beat(5, k), 2'b11, k == 3);
      tick();
    end
    chk("after_rst_idle", 64'(o_valid), 64'(1'b0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axis_downsizer.md
Name: axis_downsizer

Overview:
- Width down-converter for byte-keyed AXI-stream.
- Accepts one wide word per handshake and emits it as RATIO narrow beats, lowest byte lane first.
- Trims empty trailing slices of the final word of a packet.
- Sits between the wide stack datapath and narrower MAC/host-side ports; the read-out counterpart of the stack's word-packing upsizer path.

Parameters:
- IN_BYTES, 8, input word width in bytes; must be a multiple of RATIO.
- RATIO, 4, output beats per full input word; power of two, at least 2.
- OUT_BYTES, IN_BYTES/RATIO, derived output width in bytes; never overridden.

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- i_valid  in  1  input word valid
- i_ready  out  1  input word accepted when i_valid && i_ready
- i_data  in  8*IN_BYTES  input word, byte 0 in bits [7:0]
- i_keep  in  IN_BYTES  byte-valid mask
- i_last  in  1  final word of packet
- o_valid  out  1  output beat valid
- o_ready  in  1  downstream ready
- o_data  out  8*OUT_BYTES  output slice
- o_keep  out  OUT_BYTES  slice byte mask
- o_last  out  1  final beat of packet

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- State:
  - Holding register: word, keep, last, valid.
  - Slice index idx, log2(RATIO) bits.
  - End index fin, the index of the final slice to emit for the held word.
- Reset values: hold valid=0, idx=0. Outputs o_valid=0, o_last=0, o_keep=0. o_data don't-care. i_ready=1 from the first cycle after reset.
- Capture on i_valid && i_ready:
  - Load word, keep and last into the holding register; set idx=0.
  - If i_last=1: fin = highest slice index with any keep bit set.
  - If i_last=1 and i_keep=0: fin=0.
  - If i_last=0: fin=RATIO-1.
- Outputs:
  - o_valid = hold valid.
  - o_data and o_keep = slice idx of the held word.
  - o_last = held last && (idx==fin).
  - o_keep is passed through unmodified; interior zero lanes are not compacted.
- Advance on o_valid && o_ready:
  - If idx != fin: idx increments.
  - If idx == fin: the word is retired. Hold valid clears, unless a new word is captured in the same cycle.
- i_ready = !hold valid || (idx==fin && o_ready). This is combinational from o_ready. Back-to-back words therefore produce no output bubbles.
- Latency: first output beat is visible the cycle after input capture.
- Throughput:
  - Sustained one output beat per cycle.
  - One input word per RATIO cycles when full; fewer when a last word is trimmed.
- Contract: non-last words must have all keep bits set. Behaviour for violations is undefined; the bench asserts on it.
- Zero-keep last word emits exactly one beat with keep=0, last=1. The packet boundary is never dropped.
- Stall: with o_valid=1 and o_ready=0, o_data, o_keep and o_last stay stable and idx holds.
- Reset mid-word: the held word is discarded, o_valid=0 on the following cycle, and the next word starts at slice 0.

Decomposition:
- Shared package axis_pkg holds:
  - function last_slice(keep, ratio), which returns fin;
  - the localparam for index width, clog2 of RATIO.
- No sub-module. Output is already registered; users needing timing isolation on i_ready place the existing AXI-stream register slice upstream.

Test Plan (IN_BYTES=8, RATIO=4):
1. Reset -> o_valid=0, o_last=0, i_ready=1 on the cycle after rst deasserts.
2. Full packet, o_ready=1: word 0x8877665544332211, keep 0xFF, last=1 -> four beats 0x2211, 0x4433, 0x6655, 0x8877, keep 0x3 each. o_last=1 only on the 4th beat. i_ready low for exactly 3 cycles.
3. Trimmed last: keep 0x07, last=1 -> 2 beats: 0x2211 keep 0x3, then 0x4433 keep 0x1 last=1. Next word is accepted on the 2nd beat's handshake.
4. Zero-keep last: keep 0x00, last=1 -> single beat keep 0x0, last=1.
5. Backpressure: 8 full words with o_ready pattern 1,0,1,0 repeating -> 32 beats in order. Outputs stable during every stall. No loss or duplication.
6. Continuous streaming: i_valid held high for 8 words, o_ready=1 -> o_valid high for 32 consecutive cycles. Reset mid-word after the 2nd beat -> o_valid=0 next cycle, and the next word's first beat is slice 0.
